// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdp_pkg
// Brief    : Shared codes, FSM encodings and status bit positions for the
//            VDP host port.
// Revision : 1.0
// ============================================================================
package vdp_pkg;

    localparam logic [1:0] CODE_VRAM_RD = 2'd0;
    localparam logic [1:0] CODE_VRAM_WR = 2'd1;
    localparam logic [1:0] CODE_REG_WR  = 2'd2;
    localparam logic [1:0] CODE_CRAM_WR = 2'd3;

    localparam int STAT_FRAME_BIT = 7;
    localparam int STAT_OVF_BIT   = 6;
    localparam int STAT_COLL_BIT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_RD_CAP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_CTRL_WR = 3'd1,
        EV_DATA_WR = 3'd2,
        EV_DATA_RD = 3'd3,
        EV_CTRL_RD = 3'd4
    } event_e;

endpackage
`default_nettype wire

// File: rtl/strobe_edge.sv
`default_nettype none
// ============================================================================
// Module   : strobe_edge
// Brief    : Rise/fall detector for a level strobe sampled on clk.
// Revision : 1.0
// ============================================================================
module strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise,
    output logic fall
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= strobe;
        end
    end

    assign rise = strobe & ~r_prev;
    assign fall = ~strobe & r_prev;

endmodule
`default_nettype wire

// File: rtl/vdp_host_port.sv
`default_nettype none
// ============================================================================
// Module   : vdp_host_port
// Brief    : Z80 control/data port responder: address/code decode, VRAM/CRAM
//            writes, prefetch reads, register writes and status flags.
// Revision : 1.0
// ============================================================================
module vdp_host_port
    import vdp_pkg::*;
#(
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               control_wr,
    input  logic               control_rd,
    input  logic               data_wr,
    input  logic               data_rd,
    input  logic [7:0]         control_i,
    input  logic [7:0]         data_i,
    output logic [7:0]         control_o,
    output logic [7:0]         data_o,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic [4:0]         cram_addr,
    output logic               cram_we,
    output logic [11:0]        cram_wdata,
    output logic               reg_we,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_data,
    input  logic               frame_set,
    input  logic               ovf_set,
    input  logic               coll_set,
    input  logic               frame_irq_en,
    output logic               irq_n
);

    logic w_cw_rise, w_cw_fall, w_cr_rise, w_cr_fall;
    logic w_dw_rise, w_dw_fall, w_dr_rise, w_dr_fall;

    strobe_edge u_cw_edge (.clk(clk), .rst_n(rst_n), .strobe(control_wr), .rise(w_cw_rise), .fall(w_cw_fall));
    strobe_edge u_cr_edge (.clk(clk), .rst_n(rst_n), .strobe(control_rd), .rise(w_cr_rise), .fall(w_cr_fall));
    strobe_edge u_dw_edge (.clk(clk), .rst_n(rst_n), .strobe(data_wr),    .rise(w_dw_rise), .fall(w_dw_fall));
    strobe_edge u_dr_edge (.clk(clk), .rst_n(rst_n), .strobe(data_rd),    .rise(w_dr_rise), .fall(w_dr_fall));

    logic w_unused;
    assign w_unused = &{1'b0, w_cw_fall, w_cr_rise, w_dw_fall, w_dr_fall};

    state_e             r_state;
    logic [VRAM_AW-1:0] r_addr;
    logic [1:0]         r_code;
    logic               r_first_done;
    logic [7:0]         r_first_byte;
    logic [7:0]         r_cram_latch;
    logic               r_frame, r_ovf, r_coll;
    logic               r_pend_valid;
    event_e             r_pend_ev;
    logic [7:0]         r_pend_byte;

    event_e             w_ev;
    logic [7:0]         w_ev_byte;
    event_e             w_do_ev;
    logic [7:0]         w_do_byte;
    logic               w_clr;
    logic [VRAM_AW-1:0] w_cw_addr;
    logic [VRAM_AW-1:0] w_addr_inc;

    // Bus timing allows at most one new access per cycle; priority only matters off-spec.
    always_comb begin
        w_ev      = EV_NONE;
        w_ev_byte = 8'h00;
        if (w_cw_rise) begin
            w_ev      = EV_CTRL_WR;
            w_ev_byte = control_i;
        end else if (w_dw_rise) begin
            w_ev      = EV_DATA_WR;
            w_ev_byte = data_i;
        end else if (w_dr_rise) begin
            w_ev = EV_DATA_RD;
        end else if (w_cr_fall) begin
            w_ev = EV_CTRL_RD;
        end
    end

    assign w_do_ev    = r_pend_valid ? r_pend_ev   : w_ev;
    assign w_do_byte  = r_pend_valid ? r_pend_byte : w_ev_byte;
    assign w_clr      = (r_state == ST_IDLE) && (w_do_ev == EV_CTRL_RD);
    assign w_cw_addr  = VRAM_AW'({w_do_byte[5:0], r_addr[7:0]});
    assign w_addr_inc = r_addr + VRAM_AW'(1);

    always_comb begin
        control_o                 = 8'h00;
        control_o[STAT_FRAME_BIT] = r_frame;
        control_o[STAT_OVF_BIT]   = r_ovf;
        control_o[STAT_COLL_BIT]  = r_coll;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_code       <= CODE_VRAM_RD;
            r_first_done <= 1'b0;
            r_first_byte <= 8'h00;
            r_cram_latch <= 8'h00;
            r_frame      <= 1'b0;
            r_ovf        <= 1'b0;
            r_coll       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_ev    <= EV_NONE;
            r_pend_byte  <= 8'h00;
            data_o       <= 8'h00;
            vram_addr    <= '0;
            vram_we      <= 1'b0;
            vram_wdata   <= 8'h00;
            cram_addr    <= 5'd0;
            cram_we      <= 1'b0;
            cram_wdata   <= 12'h000;
            reg_we       <= 1'b0;
            reg_addr     <= 4'd0;
            reg_data     <= 8'h00;
            irq_n        <= 1'b1;
        end else begin
            vram_we <= 1'b0;
            cram_we <= 1'b0;
            reg_we  <= 1'b0;

            // A set pulse coinciding with the read-clear keeps the flag.
            r_frame <= frame_set | (r_frame & ~w_clr);
            r_ovf   <= ovf_set   | (r_ovf   & ~w_clr);
            r_coll  <= coll_set  | (r_coll  & ~w_clr);
            irq_n   <= ~(r_frame & frame_irq_en);

            if (r_state != ST_IDLE) begin
                if (w_ev != EV_NONE && !r_pend_valid) begin
                    r_pend_valid <= 1'b1;
                    r_pend_ev    <= w_ev;
                    r_pend_byte  <= w_ev_byte;
                end
            end else if (r_pend_valid) begin
                if (w_ev != EV_NONE) begin
                    r_pend_ev   <= w_ev;
                    r_pend_byte <= w_ev_byte;
                end else begin
                    r_pend_valid <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    case (w_do_ev)
                        EV_CTRL_WR: begin
                            if (!r_first_done) begin
                                r_addr[7:0]  <= w_do_byte;
                                r_first_byte <= w_do_byte;
                                r_first_done <= 1'b1;
                            end else begin
                                r_first_done <= 1'b0;
                                r_addr       <= w_cw_addr;
                                r_code       <= w_do_byte[7:6];
                                if (w_do_byte[7:6] == CODE_VRAM_RD) begin
                                    vram_addr <= w_cw_addr;
                                    r_state   <= ST_RD_REQ;
                                end else if (w_do_byte[7:6] == CODE_REG_WR) begin
                                    reg_we   <= 1'b1;
                                    reg_addr <= w_do_byte[3:0];
                                    reg_data <= r_first_byte;
                                end
                            end
                        end
                        EV_DATA_WR: begin
                            r_first_done <= 1'b0;
                            data_o       <= w_do_byte;
                            r_addr       <= w_addr_inc;
                            if (r_code != CODE_CRAM_WR) begin
                                vram_addr  <= r_addr;
                                vram_wdata <= w_do_byte;
                                vram_we    <= 1'b1;
                            end else if (!r_addr[0]) begin
                                r_cram_latch <= w_do_byte;
                            end else begin
                                cram_we    <= 1'b1;
                                cram_addr  <= r_addr[5:1];
                                cram_wdata <= {w_do_byte[3:0], r_cram_latch};
                            end
                        end
                        EV_DATA_RD: begin
                            r_first_done <= 1'b0;
                            vram_addr    <= r_addr;
                            r_state      <= ST_RD_REQ;
                        end
                        EV_CTRL_RD: begin
                            r_first_done <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    data_o  <= vram_rdata;
                    r_addr  <= w_addr_inc;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_host_port
// Brief    : Directed self-checking bench for vdp_host_port with a VRAM model.
// Revision : 1.0
// ============================================================================
module tb_vdp_host_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        control_wr = 1'b0, control_rd = 1'b0, data_wr = 1'b0, data_rd = 1'b0;
    logic [7:0]  control_i = 8'h00, data_i = 8'h00;
    logic [7:0]  control_o, data_o;
    logic [13:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic [4:0]  cram_addr;
    logic        cram_we;
    logic [11:0] cram_wdata;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        frame_set = 1'b0, ovf_set = 1'b0, coll_set = 1'b0, frame_irq_en = 1'b0;
    logic        irq_n;

    vdp_host_port #(.VRAM_AW(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .control_wr(control_wr), .control_rd(control_rd), .data_wr(data_wr), .data_rd(data_rd),
        .control_i(control_i), .data_i(data_i), .control_o(control_o), .data_o(data_o),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .cram_addr(cram_addr), .cram_we(cram_we), .cram_wdata(cram_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .frame_set(frame_set), .ovf_set(ovf_set), .coll_set(coll_set),
        .frame_irq_en(frame_irq_en), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [0:16383];
    always @(posedge clk) begin
        if (vram_we) vram[vram_addr] <= vram_wdata;
        vram_rdata <= vram[vram_addr];
    end

    int n_cmp = 0, n_bad = 0;
    int n_vram_we = 0, n_cram_we = 0, n_reg_we = 0;
    logic [3:0]  last_reg_addr = 4'd0;
    logic [7:0]  last_reg_data = 8'h00;
    logic [4:0]  last_cram_addr = 5'd0;
    logic [11:0] last_cram_wdata = 12'h000;

    always @(posedge clk) begin
        if (vram_we) n_vram_we++;
        if (cram_we) begin
            n_cram_we++;
            last_cram_addr  = cram_addr;
            last_cram_wdata = cram_wdata;
        end
        if (reg_we) begin
            n_reg_we++;
            last_reg_addr = reg_addr;
            last_reg_data = reg_data;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ctrl_wr(input logic [7:0] b);
        @(negedge clk); control_i = b; control_wr = 1'b1;
        repeat (4) @(negedge clk);
        control_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic dat_wr(input logic [7:0] b);
        @(negedge clk); data_i = b; data_wr = 1'b1;
        repeat (4) @(negedge clk);
        data_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ctrl_rd();
        @(negedge clk); control_rd = 1'b1;
        repeat (4) @(negedge clk);
        control_rd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        vram[14'h3F3F] = 8'h5A;
        vram[14'h3F40] = 8'h77;
        vram[14'h0010] = 8'hEE;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_control_o", control_o, 8'h00);
        chk("rst_data_o", data_o, 8'h00);
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_strobes", {vram_we, cram_we, reg_we}, 3'b000);
        chk("rst_vram_addr", vram_addr, 14'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_irq_n", irq_n, 1'b1);

        // VRAM write with auto-increment, one-clock write pulses
        ctrl_wr(8'h34);
        ctrl_wr(8'h40);
        dat_wr(8'hAA);
        dat_wr(8'hBB);
        chk("vram_0034", vram[14'h0034], 8'hAA);
        chk("vram_0035", vram[14'h0035], 8'hBB);
        chk("vram_we_pulses", n_vram_we, 2);
        chk("dw_buffer", data_o, 8'hBB);

        // Prefetch from control write, code 0, with exact latency
        ctrl_wr(8'h3F);
        @(negedge clk); control_i = 8'h3F; control_wr = 1'b1;
        @(negedge clk); chk("pf_vram_addr", vram_addr, 14'h3F3F);
        @(negedge clk); chk("pf_not_yet", data_o, 8'hBB);
        @(negedge clk); chk("pf_data", data_o, 8'h5A);
        @(negedge clk); control_wr = 1'b0;
        repeat (3) @(negedge clk);

        // Data read returns buffer and prefetches the next location
        @(negedge clk); data_rd = 1'b1;
        @(negedge clk);
        chk("dr_hold", data_o, 8'h5A);
        chk("dr_vram_addr", vram_addr, 14'h3F40);
        @(negedge clk);
        @(negedge clk); chk("dr_data", data_o, 8'h77);
        @(negedge clk); data_rd = 1'b0;
        repeat (3) @(negedge clk);
        dat_wr(8'h11);
        chk("after_pf_write", vram[14'h3F41], 8'h11);

        // Register write
        ctrl_wr(8'h12);
        ctrl_wr(8'h81);
        chk("reg_we_count", n_reg_we, 1);
        chk("reg_addr", last_reg_addr, 4'd1);
        chk("reg_data", last_reg_data, 8'h12);
        dat_wr(8'h99);
        chk("reg_then_vram", vram[14'h0112], 8'h99);

        // CRAM write pair
        ctrl_wr(8'h04);
        ctrl_wr(8'hC0);
        dat_wr(8'h2F);
        dat_wr(8'h0C);
        chk("cram_we_count", n_cram_we, 1);
        chk("cram_addr", last_cram_addr, 5'd2);
        chk("cram_wdata", last_cram_wdata, 12'hC2F);
        chk("cram_no_vram", n_vram_we, 4);

        // Frame flag, IRQ and clear on control read falling edge
        @(negedge clk); frame_irq_en = 1'b1; frame_set = 1'b1;
        @(negedge clk); frame_set = 1'b0;
        chk("frame_status", control_o, 8'h80);
        @(negedge clk); chk("irq_asserted", irq_n, 1'b0);
        @(negedge clk); control_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("cr_holds_flag", control_o, 8'h80);
        @(negedge clk); control_rd = 1'b0;
        @(negedge clk); chk("cr_cleared", control_o, 8'h00);
        @(negedge clk); chk("irq_released", irq_n, 1'b1);

        // Set on the clearing cycle wins
        @(negedge clk); frame_set = 1'b1;
        @(negedge clk); frame_set = 1'b0; control_rd = 1'b1;
        repeat (4) @(negedge clk);
        control_rd = 1'b0; frame_set = 1'b1;
        @(negedge clk); frame_set = 1'b0;
        chk("set_wins", control_o, 8'h80);
        @(negedge clk); ovf_set = 1'b1; coll_set = 1'b1;
        @(negedge clk); ovf_set = 1'b0; coll_set = 1'b0;
        chk("all_flags", control_o, 8'hE0);
        ctrl_rd();
        chk("all_cleared", control_o, 8'h00);

        // Address wrap
        ctrl_wr(8'hFF);
        ctrl_wr(8'h7F);
        dat_wr(8'h42);
        dat_wr(8'h43);
        chk("wrap_3fff", vram[14'h3FFF], 8'h42);
        chk("wrap_0000", vram[14'h0000], 8'h43);
        chk("wrap_vram_addr", vram_addr, 14'h0000);

        // Control read resets the byte pairing
        ctrl_wr(8'h55);
        ctrl_rd();
        ctrl_wr(8'h66);
        ctrl_wr(8'h40);
        dat_wr(8'h31);
        chk("pair_reset_data", vram[14'h0066], 8'h31);
        chk("pair_reset_addr", vram_addr, 14'h0066);

        // Reset during a prefetch aborts it
        ctrl_wr(8'h10);
        @(negedge clk); control_i = 8'h00; control_wr = 1'b1;
        @(negedge clk); rst_n = 1'b0; control_wr = 1'b0;
        #1;
        chk("async_rst_data_o", data_o, 8'h00);
        chk("async_rst_vram_addr", vram_addr, 14'h0000);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_abort_data_o", data_o, 8'h00);
        chk("rst_abort_irq_n", irq_n, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
